// File: rtl/matrix_result_streamer.sv
// Streams one captured packed matrix out row-major, one signed element per beat.
// First element is valid one cycle after load acceptance; out_ready low stalls with all outputs held.
module matrix_result_streamer #(
   parameter  int ELEM_W  = 8,
   parameter  int MAX_DIM = 5,
   localparam int RC_W    = $clog2(MAX_DIM),
   localparam int DIM_W   = $clog2(MAX_DIM + 1),
   localparam int K_W     = $clog2(MAX_DIM * MAX_DIM),
   localparam int VEC_W   = MAX_DIM * MAX_DIM * ELEM_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [VEC_W-1:0]  load_matrix,
   input  logic [1:0]        load_size,
   input  logic              load_overflow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ELEM_W-1:0] out_data,
   output logic [RC_W-1:0]   out_row,
   output logic [RC_W-1:0]   out_col,
   output logic              out_last,
   output logic              out_overflow,
   output logic              busy
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t             state_q, state_d;
   logic               armed_q;
   logic [VEC_W-1:0]   mat_q;
   logic [DIM_W-1:0]   dim_q;
   logic [RC_W-1:0]    row_q, col_q;
   logic [K_W-1:0]     k_q;
   logic               ovf_q;
   logic               capture, advance;
   logic               col_end, row_end;

   assign col_end = (col_q == RC_W'(dim_q - 1'b1));
   assign row_end = (row_q == RC_W'(dim_q - 1'b1));

   always_comb begin
      state_d    = state_q;
      capture    = 1'b0;
      advance    = 1'b0;
      load_ready = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state_q)
         IDLE: begin
            // armed_q keeps load_ready low until the first edge after reset release
            load_ready = armed_q;
            if (load_valid && armed_q) begin
               capture = 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               advance = 1'b1;
               if (col_end && row_end)
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mat_q <= '0;
         dim_q <= '0;
         ovf_q <= 1'b0;
         row_q <= '0;
         col_q <= '0;
         k_q   <= '0;
      end else if (capture) begin
         mat_q <= load_matrix;
         dim_q <= DIM_W'(load_size) + DIM_W'(2);
         ovf_q <= load_overflow;
         row_q <= '0;
         col_q <= '0;
         k_q   <= '0;
      end else if (advance) begin
         // k tracks row*dim+col so the element mux needs no multiplier
         if (col_end) begin
            col_q <= '0;
            row_q <= row_end ? '0 : row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
         k_q <= (col_end && row_end) ? '0 : k_q + 1'b1;
      end
   end

   assign out_data     = mat_q[k_q*ELEM_W +: ELEM_W];
   assign out_row      = row_q;
   assign out_col      = col_q;
   assign out_last     = (state_q == STREAM) && col_end && row_end;
   assign out_overflow = ovf_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: directed frame table, corner sequences and random frames vs. a queue model.
module tb_matrix_result_streamer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load_valid;
   logic         load_ready;
   logic [199:0] load_matrix;
   logic [1:0]   load_size;
   logic         load_overflow;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic [2:0]   out_row;
   logic [2:0]   out_col;
   logic         out_last;
   logic         out_overflow;
   logic         busy;

   matrix_result_streamer dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_ready(load_ready), .load_matrix(load_matrix),
      .load_size(load_size), .load_overflow(load_overflow),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_last(out_last),
      .out_overflow(out_overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         kind;       // 0 random, 1 directed 2x2, 2 adder 5x5
      logic [1:0] sz;
      logic       ovf;
      int         bp;         // 0 always ready, 1 pattern 1,0,0, 2 random
      int         exp_beats;
      int         exp_lr;
      int         exp_lc;
   } vec_t;

   vec_t vecs[7];
   int   checks = 0;
   int   errors = 0;
   int   got_data[25];
   int   last_r, last_c;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [199:0] rand_matrix();
      logic [199:0] m;
      for (int k = 0; k < 25; k++) m[k*8 +: 8] = 8'($urandom);
      return m;
   endfunction

   // Called at a negedge while the streamer is idle; returns at the negedge after acceptance.
   task automatic do_load(input logic [199:0] m, input logic [1:0] sz, input logic ovf);
      chk("load_ready_before_load", load_ready, 1);
      load_valid    = 1'b1;
      load_matrix   = m;
      load_size     = sz;
      load_overflow = ovf;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic stream_frame(input logic [199:0] m, input logic [1:0] sz, input logic ovf,
                               input int bp, input int intrude_at, input logic [199:0] m2,
                               input logic [1:0] sz2, output int beats, output int cycles);
      int qd[$], qr[$], qc[$], ql[$];
      int dim, n, hd, hr, hc, hl;
      bit held, done, rdy;
      dim = int'(sz) + 2;
      n = dim * dim;
      for (int k = 0; k < n; k++) begin
         qd.push_back(int'($signed(m[k*8 +: 8])));
         qr.push_back(k / dim);
         qc.push_back(k % dim);
         ql.push_back(k == n - 1 ? 1 : 0);
      end
      beats = 0; cycles = 0; held = 0; done = 0;
      hd = 0; hr = 0; hc = 0; hl = 0;
      while (!done && cycles < 400) begin
         chk("out_valid_in_frame", out_valid, 1);
         chk("busy_in_frame", busy, 1);
         chk("load_ready_in_frame", load_ready, 0);
         chk("overflow_in_frame", out_overflow, ovf);
         if (held) begin
            chk("hold_data", $signed(out_data), hd);
            chk("hold_row", out_row, hr);
            chk("hold_col", out_col, hc);
            chk("hold_last", out_last, hl);
         end
         if (qd.size() == 0) begin
            chk("extra_beat", 1, 0);
            break;
         end
         chk("data", $signed(out_data), qd[0]);
         chk("row", out_row, qr[0]);
         chk("col", out_col, qc[0]);
         chk("last", out_last, ql[0]);
         if (beats < 25) got_data[beats] = $signed(out_data);
         if (beats == intrude_at) begin
            load_valid    = 1'b1;
            load_matrix   = m2;
            load_size     = sz2;
            load_overflow = ~ovf;
         end
         case (bp)
            0:       rdy = 1'b1;
            1:       rdy = (cycles % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         if (rdy) begin
            if (out_last) begin
               last_r = out_row;
               last_c = out_col;
            end
            if (ql[0] == 1) done = 1;
            void'(qd.pop_front()); void'(qr.pop_front());
            void'(qc.pop_front()); void'(ql.pop_front());
            beats++;
            held = 0;
         end else begin
            held = 1;
            hd = $signed(out_data); hr = out_row; hc = out_col; hl = out_last;
         end
         cycles++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      if (!done) chk("frame_timeout", 0, 1);
      else begin
         chk("end_out_valid", out_valid, 0);
         chk("end_busy", busy, 0);
         chk("end_out_last", out_last, 0);
         chk("end_load_ready", load_ready, 1);
         chk("end_overflow_held", out_overflow, ovf);
      end
   endtask

   task automatic run_vec(input int idx);
      logic [199:0] m;
      int a[25], b[25];
      int beats, cycles;
      vec_t v;
      v = vecs[idx];
      m = rand_matrix();
      if (v.kind == 1) begin
         m[0 +: 8] = 8'd1; m[8 +: 8] = 8'hFE; m[16 +: 8] = 8'd3; m[24 +: 8] = 8'hFC;
      end else if (v.kind == 2) begin
         for (int k = 0; k < 25; k++) begin a[k] = 0; b[k] = 0; end
         a[0] = -90;  b[0] = 10;
         a[10] = 120; b[10] = 10;
         a[24] = 127; b[24] = 1;
         for (int k = 0; k < 25; k++) m[k*8 +: 8] = 8'(a[k] + b[k]);
      end
      do_load(m, v.sz, v.ovf);
      stream_frame(m, v.sz, v.ovf, v.bp, -1, '0, 2'd0, beats, cycles);
      chk("beats", beats, v.exp_beats);
      chk("last_row", last_r, v.exp_lr);
      chk("last_col", last_c, v.exp_lc);
      if (v.bp == 0) chk("consecutive_cycles", cycles, v.exp_beats);
      if (v.kind == 1) begin
         chk("d2_k0", got_data[0], 1);
         chk("d2_k1", got_data[1], -2);
         chk("d2_k2", got_data[2], 3);
         chk("d2_k3", got_data[3], -4);
      end else if (v.kind == 2) begin
         chk("add_beat0", got_data[0], -80);
         chk("add_beat10", got_data[10], -126);
         chk("add_beat24", got_data[24], -128);
      end
   endtask

   initial begin
      logic [199:0] ma, mb;
      logic [1:0]   rsz;
      logic         rovf;
      int           beats, cycles;

      vecs[0] = '{1, 2'd0, 1'b0, 0, 4, 1, 1};
      vecs[1] = '{2, 2'd3, 1'b1, 0, 25, 4, 4};
      vecs[2] = '{0, 2'd1, 1'b0, 1, 9, 2, 2};
      vecs[3] = '{0, 2'd2, 1'b1, 0, 16, 3, 3};
      vecs[4] = '{0, 2'd0, 1'b0, 0, 4, 1, 1};
      vecs[5] = '{0, 2'd3, 1'b0, 2, 25, 4, 4};
      vecs[6] = '{0, 2'd1, 1'b1, 2, 9, 2, 2};

      rst_n = 1'b0; load_valid = 1'b0; load_matrix = '0; load_size = 2'd0;
      load_overflow = 1'b0; out_ready = 1'b0;
      #3;
      chk("rst_load_ready", load_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_overflow", out_overflow, 0);
      chk("rst_data", out_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("release_load_ready_pre_edge", load_ready, 0);
      @(negedge clk);
      chk("release_load_ready_first_edge", load_ready, 1);

      for (int i = 0; i < 7; i++) run_vec(i);

      // A second matrix offered mid-frame must wait for the current frame to finish.
      ma = rand_matrix();
      mb = rand_matrix();
      do_load(ma, 2'd1, 1'b0);
      stream_frame(ma, 2'd1, 1'b0, 0, 3, mb, 2'd0, beats, cycles);
      chk("intrude_beats", beats, 9);
      @(negedge clk);
      load_valid = 1'b0;
      stream_frame(mb, 2'd0, 1'b1, 0, -1, '0, 2'd0, beats, cycles);
      chk("intrude_second_beats", beats, 4);

      // Asynchronous reset at beat 5 of a 4x4 frame.
      ma = rand_matrix();
      do_load(ma, 2'd2, 1'b1);
      for (int i = 0; i < 5; i++) begin
         out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("mid_row", out_row, 1);
      chk("mid_col", out_col, 1);
      chk("mid_data", $signed(out_data), int'($signed(ma[5*8 +: 8])));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_load_ready", load_ready, 0);
      chk("midrst_overflow", out_overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("midrst_release_pre_edge", load_ready, 0);
      @(negedge clk);
      chk("midrst_release_first_edge", load_ready, 1);
      run_vec(0);

      for (int i = 0; i < 8; i++) begin
         rsz  = 2'($urandom_range(0, 3));
         rovf = 1'($urandom_range(0, 1));
         ma   = rand_matrix();
         do_load(ma, rsz, rovf);
         stream_frame(ma, rsz, rovf, 2, -1, '0, 2'd0, beats, cycles);
         chk("rand_beats", beats, (int'(rsz) + 2) * (int'(rsz) + 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Reader-side companion to the packed-matrix adder.
- Accepts one packed result matrix with its size code and overflow flag through a valid/ready load handshake.
- Streams the matrix out one signed element per beat, row-major, over a valid/ready output handshake, with row/column indices and a last-element marker.
- Sits between the combinational adder output and any byte-serial consumer (UART/display formatter).

Parameters:
ELEM_W, 8, element width in bits (signed two's complement)
MAX_DIM, 5, maximum matrix dimension; packed vector width is MAX_DIM*MAX_DIM*ELEM_W = 200

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
load_valid  in  1  a packed matrix is presented for capture
load_ready  out  1  streamer can accept a matrix
load_matrix  in  200  packed signed matrix; element k at bits [k*8 +: 8], k = row*dim + col
load_size  in  2  size code: 00=2x2, 01=3x3, 10=4x4, 11=5x5 (dim = code + 2)
load_overflow  in  1  overflow flag accompanying the matrix
out_valid  out  1  out_data/out_row/out_col/out_last are valid
out_ready  in  1  consumer accepts the current element
out_data  out  8  signed element value
out_row  out  3  row index, 0..dim-1
out_col  out  3  column index, 0..dim-1
out_last  out  1  current element is (dim-1, dim-1)
out_overflow  out  1  captured overflow flag, held for the whole frame
busy  out  1  a frame is captured and not yet fully transferred

Behaviour:
Reset (rst_n low, asynchronous):
- State goes to IDLE.
- All outputs are 0, including load_ready.
- Capture registers are cleared.

After reset release:
- load_ready rises on the first clock edge.

States:
- IDLE:
  - load_ready=1, out_valid=0, busy=0.
  - When load_valid&&load_ready at a clock edge: capture load_matrix, dim, and load_overflow; clear row/col to 0; go to STREAM.
  - load_ready drops and out_valid/busy rise on that same edge, so the first element is valid the cycle after acceptance (latency 1).
- STREAM:
  - out_valid=1, busy=1, load_ready=0.
  - out_data is the captured element k = row*dim + col.
  - Transfer occurs on a clock edge with out_valid&&out_ready.
  - On transfer, when not last: col increments. When col==dim-1, col wraps to 0 and row increments.
  - On transfer of the last element (row==dim-1 && col==dim-1, out_last=1): go to IDLE. out_valid/busy/out_last drop and load_ready rises on that same edge.
  - No back-to-back capture in the last-transfer cycle.

Handshake rules:
- While out_valid=1 and out_ready=0, out_data, out_row, out_col, out_last and out_overflow are held stable.
- out_valid never drops without a transfer, except on reset.
- load_valid is ignored while load_ready=0. Input changes during STREAM do not affect the frame in flight.
- out_overflow is updated only at capture. It is held through STREAM and after return to IDLE, until the next capture or reset.
- out_data/out_row/out_col are don't-care in IDLE. The bench checks them only when out_valid=1.

Frame length and indexing:
- Exactly dim*dim transfers per frame: 4, 9, 16 or 25.
- Elements beyond dim*dim in the packed vector are never emitted.
- Element index arithmetic uses at least 5-bit unsigned.
- Element values are passed through unmodified: no saturation, no sign change.

Reset mid-frame:
- Frame is abandoned, all outputs go to 0, and no partial resumption occurs.

Test Plan:
- 2x2 frame: load_size=00, elements k0..k3 = 1,-2,3,-4, load_overflow=0, out_ready=1 held. Required response:
  - 4 beats on consecutive cycles starting 1 cycle after acceptance.
  - (row,col) = (0,0),(0,1),(1,0),(1,1); data 1,-2,3,-4.
  - out_last on beat 4 only; load_ready=1 the cycle after.
- 5x5 adder result: element k = A[k]+B[k] wrapped to 8 bits, where
  - A[0]=-90, B[0]=10; A[10]=120, B[10]=10; A[24]=127, B[24]=1;
  - load_overflow=1.
  - Required response: 25 beats; beat 0 = -80 at (0,0); beat 10 = -126 at (2,0); beat 24 = -128 at (4,4) with out_last=1; out_overflow=1 throughout.
- Backpressure on 3x3: toggle out_ready 1,0,0,1,... Required response:
  - Outputs hold stable during every out_ready=0 cycle.
  - Exactly 9 transfers occur, in order, with no duplicates or skips.
- Load during STREAM: assert load_valid with a different matrix mid-frame. Required response:
  - load_ready=0 and the new matrix is ignored.
  - The current frame completes unchanged; the new matrix is accepted only after returning to IDLE.
- Reset mid-frame: deassert rst_n asynchronously between edges at beat 5 of a 4x4 frame. Required response:
  - out_valid, busy, load_ready and out_overflow go to 0 immediately.
  - After release, load_ready=1 on the first edge.
  - The next 2x2 frame streams correctly from (0,0).
- Size change between frames: a 4x4 frame followed directly by a 2x2 frame. Required response: 16 then 4 transfers, out_last at indices (3,3) then (1,1).
